// File: rtl/harq_pkg.sv
// Shared widths, FSM encoding and saturation limits for the HARQ LLR combiner.
package harq_pkg;

  localparam int unsigned LLR_W     = 6;
  localparam int unsigned ACC_W     = 8;
  localparam int unsigned LANES     = 16;
  localparam int unsigned USER_W    = 4;
  localparam int unsigned PTR_W     = 7;
  localparam int unsigned NUM_USERS = 2 ** USER_W;
  localparam int unsigned ADDR_W    = USER_W + PTR_W;

  // Limits expressed in the one-bit-wider sum domain so the add never wraps before clamping.
  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } harq_state_e;

endpackage

// File: rtl/harq_lane_sat_add.sv
// One lane of the combine: sign-extend, saturating add, new-data select and lane mask.
module harq_lane_sat_add
  import harq_pkg::*;
(
  input  logic [LLR_W-1:0] llr,
  input  logic [ACC_W-1:0] stored,
  input  logic             ndi,
  input  logic             lane_en,
  output logic [ACC_W-1:0] result
);

  logic [ACC_W-1:0]        llr_ext;
  logic signed [ACC_W:0]   sum;

  // Combine one lane; masked lanes pass the stored value through untouched.
  always_comb begin
    llr_ext = {{(ACC_W - LLR_W){llr[LLR_W-1]}}, llr};
    sum     = {stored[ACC_W-1], stored} + {llr_ext[ACC_W-1], llr_ext};
    if (!lane_en) begin
      result = stored;
    end else if (ndi) begin
      result = llr_ext;
    end else if (sum > SUM_MAX) begin
      result = SUM_MAX[ACC_W-1:0];
    end else if (sum < SUM_MIN) begin
      result = SUM_MIN[ACC_W-1:0];
    end else begin
      result = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/harq_llr_combine.sv
// HARQ soft-buffer combiner: read stored word, combine or overwrite per lane, write back.
module harq_llr_combine
  import harq_pkg::*;
(
  input  logic                   i_core_clk,
  input  logic                   i_rx_rstn,
  input  logic                   i_rdm_slot_start,
  input  logic [LANES*LLR_W-1:0] i_harq_data,
  input  logic                   i_harq_valid,
  input  logic [3:0]             i_harq_amount,
  input  logic [USER_W-1:0]      i_harq_user_index,
  input  logic [NUM_USERS-1:0]   i_ndi,
  output logic                   o_mem_rd_en,
  output logic [ADDR_W-1:0]      o_mem_rd_addr,
  input  logic [LANES*ACC_W-1:0] i_mem_rd_data,
  output logic                   o_mem_wr_en,
  output logic [ADDR_W-1:0]      o_mem_wr_addr,
  output logic [LANES*ACC_W-1:0] o_mem_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [USER_W-1:0]      o_done_user,
  output logic                   o_ovf
);

  localparam logic [PTR_W-1:0] PTR_MAX = '1;

  logic [PTR_W-1:0]       ptr_q [NUM_USERS];
  logic                   ovf_q;
  logic [PTR_W-1:0]       cur_ptr;
  logic [ADDR_W-1:0]      beat_addr;

  logic                   s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
  logic [ADDR_W-1:0]      s1_addr_q, s2_addr_q, s3_addr_q, s4_addr_q;
  logic [LANES*LLR_W-1:0] s1_data_q, s2_data_q;
  logic [3:0]             s1_amount_q, s2_amount_q;
  logic                   s1_ndi_q, s2_ndi_q;
  logic [USER_W-1:0]      s1_user_q;
  logic [LANES*ACC_W-1:0] s3_data_q, s4_data_q;
  logic [LANES*ACC_W-1:0] stored_word, comb_word;

  harq_state_e            state_q;
  logic                   drain_cnt_q;
  logic                   burst_end;
  logic [1:0]             done_pipe_q;
  logic [USER_W-1:0]      done_user_q [2];
  logic                   done_q;
  logic [USER_W-1:0]      done_user_out_q;

  // A beat in the slot-start cycle already sees cleared pointers.
  always_comb begin
    cur_ptr   = i_rdm_slot_start ? '0 : ptr_q[i_harq_user_index];
    beat_addr = {i_harq_user_index, cur_ptr};
    burst_end = s1_valid_q && !i_harq_valid;
  end

  // Per-user pointers saturate at the last word and flag overflow instead of wrapping.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      ptr_q <= '{default: '0};
      ovf_q <= 1'b0;
    end else if (i_rdm_slot_start) begin
      ptr_q <= '{default: '0};
      ovf_q <= 1'b0;
      if (i_harq_valid) begin
        ptr_q[i_harq_user_index] <= PTR_W'(1);
      end
    end else if (i_harq_valid) begin
      if (ptr_q[i_harq_user_index] == PTR_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        ptr_q[i_harq_user_index] <= ptr_q[i_harq_user_index] + 1'b1;
      end
    end
  end

  // Beat pipeline: read issue, combine, write issue, plus one retired write for forwarding.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_amount_q <= '0;
      s1_ndi_q    <= 1'b0;
      s1_user_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_data_q   <= '0;
      s2_amount_q <= '0;
      s2_ndi_q    <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_addr_q   <= '0;
      s3_data_q   <= '0;
      s4_valid_q  <= 1'b0;
      s4_addr_q   <= '0;
      s4_data_q   <= '0;
    end else begin
      s1_valid_q  <= i_harq_valid;
      s1_addr_q   <= beat_addr;
      s1_data_q   <= i_harq_data;
      s1_amount_q <= i_harq_amount;
      s1_ndi_q    <= i_ndi[i_harq_user_index];
      s1_user_q   <= i_harq_user_index;
      s2_valid_q  <= s1_valid_q;
      s2_addr_q   <= s1_addr_q;
      s2_data_q   <= s1_data_q;
      s2_amount_q <= s1_amount_q;
      s2_ndi_q    <= s1_ndi_q;
      s3_valid_q  <= s2_valid_q;
      s3_addr_q   <= s2_addr_q;
      s3_data_q   <= comb_word;
      s4_valid_q  <= s3_valid_q;
      s4_addr_q   <= s3_addr_q;
      s4_data_q   <= s3_data_q;
    end
  end

  // Forward writes the SRAM read could not have observed; the newest write wins.
  always_comb begin
    if (s3_valid_q && (s3_addr_q == s2_addr_q)) begin
      stored_word = s3_data_q;
    end else if (s4_valid_q && (s4_addr_q == s2_addr_q)) begin
      stored_word = s4_data_q;
    end else begin
      stored_word = i_mem_rd_data;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    harq_lane_sat_add u_lane (
      .llr     (s2_data_q[k*LLR_W +: LLR_W]),
      .stored  (stored_word[k*ACC_W +: ACC_W]),
      .ndi     (s2_ndi_q),
      .lane_en (4'(k) <= s2_amount_q),
      .result  (comb_word[k*ACC_W +: ACC_W])
    );
  end

  // Burst FSM; a new beat during drain/done restarts RUN without touching the pipeline.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q     <= StIdle;
      drain_cnt_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (i_harq_valid) state_q <= StRun;
        StRun: begin
          if (!i_harq_valid) begin
            state_q     <= StDrain;
            drain_cnt_q <= 1'b0;
          end
        end
        StDrain: begin
          if (i_harq_valid) begin
            state_q <= StRun;
          end else if (drain_cnt_q) begin
            state_q <= StDone;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        StDone: state_q <= i_harq_valid ? StRun : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Done is timed off the burst's last beat so overlapping bursts each get their own pulse.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      done_pipe_q     <= '0;
      done_user_q     <= '{default: '0};
      done_q          <= 1'b0;
      done_user_out_q <= '0;
    end else begin
      done_pipe_q     <= {done_pipe_q[0], burst_end};
      done_user_q[0]  <= s1_user_q;
      done_user_q[1]  <= done_user_q[0];
      done_q          <= done_pipe_q[1];
      done_user_out_q <= done_pipe_q[1] ? done_user_q[1] : '0;
    end
  end

  assign o_mem_rd_en   = s1_valid_q;
  assign o_mem_rd_addr = s1_addr_q;
  assign o_mem_wr_en   = s3_valid_q;
  assign o_mem_wr_addr = s3_addr_q;
  assign o_mem_wr_data = s3_data_q;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = done_q;
  assign o_done_user   = done_user_out_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_harq_llr_combine.sv
// Scoreboard bench: stimulus pushes expected SRAM writes and done users, a monitor pops and checks.
module tb_harq_llr_combine;

  logic         clk;
  logic         rst_n;
  logic         slot_start;
  logic [95:0]  harq_data;
  logic         harq_valid;
  logic [3:0]   harq_amount;
  logic [3:0]   harq_user;
  logic [15:0]  ndi;
  logic         mem_rd_en;
  logic [10:0]  mem_rd_addr;
  logic [127:0] mem_rd_data;
  logic         mem_wr_en;
  logic [10:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic         busy;
  logic         done;
  logic [3:0]   done_user;
  logic         ovf;

  harq_llr_combine dut (
    .i_core_clk        (clk),
    .i_rx_rstn         (rst_n),
    .i_rdm_slot_start  (slot_start),
    .i_harq_data       (harq_data),
    .i_harq_valid      (harq_valid),
    .i_harq_amount     (harq_amount),
    .i_harq_user_index (harq_user),
    .i_ndi             (ndi),
    .o_mem_rd_en       (mem_rd_en),
    .o_mem_rd_addr     (mem_rd_addr),
    .i_mem_rd_data     (mem_rd_data),
    .o_mem_wr_en       (mem_wr_en),
    .o_mem_wr_addr     (mem_wr_addr),
    .o_mem_wr_data     (mem_wr_data),
    .o_busy            (busy),
    .o_done            (done),
    .o_done_user       (done_user),
    .o_ovf             (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 1-cycle read latency, read-during-write returns old data.
  logic [127:0] mem [2048];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  typedef struct packed {
    logic [10:0]  addr;
    logic [127:0] data;
  } wr_exp_t;

  wr_exp_t    exp_q[$];
  logic [3:0] done_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  bit         sb_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [95:0] f6(input logic [5:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] f8(input logic [7:0] v);
    return {16{v}};
  endfunction

  // Monitor: every write and every done pulse is matched against the scoreboard.
  initial begin
    wr_exp_t e;
    logic [3:0] u;
    forever begin
      @(negedge clk);
      if (sb_en && mem_wr_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL wr_unexpected: got addr %h data %h required no write", mem_wr_addr,
                   mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 128'(mem_wr_addr), 128'(e.addr));
          check("wr_data", mem_wr_data, e.data);
        end
        last_wr_cyc = cyc;
      end
      if (sb_en && done) begin
        if (done_q.size() == 0) begin
          n_total++;
          $display("FAIL done_unexpected: got user %0d required no done", done_user);
        end else begin
          u = done_q.pop_front();
          check("done_user", 128'(done_user), 128'(u));
          check("done_gap", 128'(cyc - last_wr_cyc), 128'(1));
        end
      end
    end
  end

  task automatic drive(input logic [3:0] u, input logic [3:0] amt, input logic [95:0] d);
    @(posedge clk); #1;
    harq_valid  = 1'b1;
    harq_user   = u;
    harq_amount = amt;
    harq_data   = d;
  endtask

  task automatic beat(input logic [3:0] u, input logic [3:0] amt, input logic [95:0] d,
                      input logic [10:0] ea, input logic [127:0] ed);
    drive(u, amt, d);
    exp_q.push_back('{addr: ea, data: ed});
  endtask

  task automatic end_burst(input logic [3:0] u);
    @(posedge clk); #1;
    harq_valid = 1'b0;
    done_q.push_back(u);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("drain_in_time", 128'(t < 300), 128'(1));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    rst_n = 1'b0; slot_start = 1'b0; harq_valid = 1'b0; harq_data = '0;
    harq_amount = '0; harq_user = '0; ndi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 128'(mem_rd_en), 0);
    check("rst_wr_en", 128'(mem_wr_en), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    check("rst_ovf", 128'(ovf), 0);
    @(negedge clk) rst_n = 1'b1;

    // Plain combine into zeroed words, user 3.
    beat(4'd3, 4'd15, f6(6'd5), 11'h180, f8(8'd5));
    beat(4'd3, 4'd15, f6(6'd5), 11'h181, f8(8'd5));
    end_burst(4'd3);
    check("busy_in_burst", 128'(busy), 1);
    wait_drain();

    // Saturation both ways: lanes 0-7 100+31, lanes 8-15 -120-32.
    mem[11'h200] = {{8{8'h88}}, {8{8'h64}}};
    beat(4'd4, 4'd15, {{8{6'h20}}, {8{6'h1F}}}, 11'h200, {{8{8'h80}}, {8{8'h7F}}});
    end_burst(4'd4);
    wait_drain();

    // Lane mask on the last beat.
    mem[11'h280] = f8(8'd7);
    mem[11'h281] = f8(8'd7);
    beat(4'd5, 4'd15, f6(6'd1), 11'h280, f8(8'd8));
    beat(4'd5, 4'd3, f6(6'd1), 11'h281, {{12{8'h07}}, {4{8'h08}}});
    end_burst(4'd5);
    wait_drain();

    // New data overwrites regardless of stored 50.
    mem[11'h100] = f8(8'd50);
    ndi = 16'h0004;
    beat(4'd2, 4'd15, f6(6'h3C), 11'h100, f8(8'hFC));
    end_burst(4'd2);
    wait_drain();
    ndi = '0;

    // Two bursts of user 1 append; second starts in the drain window.
    for (int i = 0; i < 3; i++) beat(4'd1, 4'd15, f6(6'd2), 11'h080 + 11'(i), f8(8'd2));
    end_burst(4'd1);
    for (int i = 3; i < 5; i++) beat(4'd1, 4'd15, f6(6'd2), 11'h080 + 11'(i), f8(8'd2));
    end_burst(4'd1);
    wait_drain();
    @(posedge clk); #1 slot_start = 1'b1;
    @(posedge clk); #1 slot_start = 1'b0;
    beat(4'd1, 4'd15, f6(6'd2), 11'h080, f8(8'd4));
    end_burst(4'd1);
    wait_drain();

    // 129 beats to user 0: pointer saturates, last two beats share 0x07F via forwarding.
    for (int i = 1; i <= 129; i++) begin
      drive(4'd0, 4'd15, f6(6'd1));
      if (i == 128) check("ovf_before_sat", 128'(ovf), 0);
      if (i == 129) check("ovf_at_sat", 128'(ovf), 1);
      if (i <= 127) exp_q.push_back('{addr: 11'(i - 1), data: f8(8'd1)});
      else if (i == 128) exp_q.push_back('{addr: 11'h07F, data: f8(8'd1)});
      else exp_q.push_back('{addr: 11'h07F, data: f8(8'd2)});
    end
    end_burst(4'd0);
    wait_drain();
    check("ovf_sticky", 128'(ovf), 1);

    // Reset mid-burst kills the in-flight write at once.
    sb_en = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'd6, 4'd15, f6(6'd3));
    check("wr_en_pre_rst", 128'(mem_wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("wr_en_in_rst", 128'(mem_wr_en), 0);
    check("rd_en_in_rst", 128'(mem_rd_en), 0);
    check("busy_in_rst", 128'(busy), 0);
    check("ovf_in_rst", 128'(ovf), 0);
    harq_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("wr_en_after_rst", 128'(mem_wr_en), 0);
    check("exp_q_empty", 128'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/harq_llr_combine.md
Name: harq_llr_combine

Overview:
- Consumes the 16-lane soft-bit beats emitted by the HARQ send stage (96-bit beat, valid, amount, user index).
- Combines each beat lane-wise with the stored HARQ soft buffer for that user using saturating addition, or overwrites the buffer on a new transmission.
- Reads and writes an external 1-cycle-latency simple-dual-port HARQ SRAM holding 16 x ACC_W bits per word.
- Word address is {user, per-user beat pointer}.

Parameters:
LLR_W, 6, signed input soft-bit width per lane
ACC_W, 8, signed stored soft-bit width per lane
LANES, 16, lanes per beat
USER_W, 4, user index width (16 users)
PTR_W, 7, per-user beat pointer width (128 words per user)

Ports:
i_core_clk  in  1  core clock
i_rx_rstn  in  1  asynchronous active-low reset
i_rdm_slot_start  in  1  one-cycle pulse; clears all user pointers and o_ovf
i_harq_data  in  LANES*LLR_W  lane k at bits [k*LLR_W+LLR_W-1 : k*LLR_W], signed
i_harq_valid  in  1  beat valid; bursts are contiguous-high with at least 1 idle cycle between them
i_harq_amount  in  4  index of the last valid lane (15 = all lanes)
i_harq_user_index  in  USER_W  user owning the beat
i_ndi  in  2**USER_W  per-user new-data flag; 1 = overwrite, 0 = combine
o_mem_rd_en  out  1  SRAM read enable
o_mem_rd_addr  out  USER_W+PTR_W  SRAM read address
i_mem_rd_data  in  LANES*ACC_W  SRAM read data, valid 1 cycle after o_mem_rd_en
o_mem_wr_en  out  1  SRAM write enable
o_mem_wr_addr  out  USER_W+PTR_W  SRAM write address
o_mem_wr_data  out  LANES*ACC_W  SRAM write data
o_busy  out  1  high from first accepted beat until o_done
o_done  out  1  one-cycle pulse after the last write of a burst
o_done_user  out  USER_W  user of the completed burst; valid with o_done
o_ovf  out  1  sticky; a beat arrived with the user pointer at max

Behaviour:
- Reset: all outputs 0; all pointers 0; FSM in IDLE; pipeline valid bits 0. Reset mid-burst abandons in-flight writes (wr_en drops immediately).
- Pointers: ptr[u], PTR_W bits per user. Each accepted beat of user u uses address {u, ptr[u]}, then ptr[u] increments. Pointers persist across bursts within a slot, so successive bursts of the same user append.
- Overflow: a beat with ptr[u] = 2**PTR_W-1 is still written. ptr[u] saturates instead of wrapping and o_ovf sets. Further beats for u overwrite the last word. o_ovf clears only on slot start or reset.
- Pipeline, beat sampled at cycle t:
  - t+1: o_mem_rd_en=1, o_mem_rd_addr = beat address. Data, amount, user and ndi are delayed alongside.
  - t+2: i_mem_rd_data is valid; compute per lane:
    - sign-extend the input lane to ACC_W;
    - if ndi: result = extended input;
    - else: result = saturate(stored + input) to [-2**(ACC_W-1), 2**(ACC_W-1)-1], i.e. -128..127;
    - lanes with index > amount: result = stored value, unchanged.
  - t+3: o_mem_wr_en=1 with registered address and data.
  - Throughput: 1 beat/cycle. Fixed read-to-write latency is 2 cycles.
- RAW hazards: none inside a burst, since every beat has a distinct address. The same address is only reused after pointer saturation. In that case the write at t+3 and the read of the next beat at t+2 collide, so a bypass forwards the pending write data into the combine when addresses match.
- FSM states:
  - IDLE → RUN on i_harq_valid.
  - RUN → DRAIN when i_harq_valid falls.
  - DRAIN → DONE once the last write has issued (2 cycles).
  - DONE → IDLE after 1 cycle, asserting o_done and o_done_user.
  - A valid arriving in DRAIN or DONE is accepted normally and does not disturb the pipeline; its burst gets its own DONE.
- o_busy = (state != IDLE).
- Slot start:
  - Clears pointers and o_ovf in the cycle it is sampled.
  - A beat sampled in that same cycle uses pointer 0, and the pointer becomes 1.
  - In-flight beats keep their already-computed addresses.
- ndi is sampled per beat together with the beat data.

Decomposition:
- Package harq_pkg holds the widths (LLR_W, ACC_W, LANES, USER_W, PTR_W), the FSM state encoding, and the saturation limit constants.
- One sub-module: harq_lane_sat_add. It is combinational and handles one lane: sign-extend, add, saturate, ndi select, lane mask. It is instantiated LANES times.

Test Plan:
- Reset, then user 3, ndi=0, stored words all 0, a 2-beat burst with all lanes +5 and amount 15 → writes to addr 0x180 and 0x181 with all lanes 5; o_done pulses at write+1 with o_done_user=3.
- Stored lane 100, input +31, ndi=0 → 127 (saturated). Stored -120, input -32 → -128.
- Last beat amount=3, stored lanes 7, input 1 → lanes 0-3 = 8, lanes 4-15 = 7.
- ndi[2]=1, stored 50, input -4 → -4. The read is issued but the stored value is ignored.
- User 1: two bursts of 3 and 2 beats → addresses 0x080-0x084 in order. Slot start, then another beat → address 0x080 again.
- Drive 129 beats to user 0 → o_ovf set at beat 128. Beats 128-129 combine into addr 0x07F using the bypass, and the result equals the sequential sum. Reset asserted mid-burst → o_mem_wr_en=0 immediately.
